// File: rtl/sram_8kx32_arbiter.sv
// ---------------------------------------------------------------------------
// sram_8kx32_arbiter
//
// Two-port arbiter in front of a single-ported 8K x 32 synchronous SRAM.
// Each requester presents req together with a command (byte write enables,
// word address, write data). The command is accepted on a cycle where
// req & gnt are both high. Grants are combinational from the arbitration
// state and the current requests, so the SRAM is driven in the same cycle.
//
// Arbitration: a port that owns the SRAM keeps it while it keeps requesting,
// until it has been granted BURST_MAX consecutive times while the other port
// is also waiting. From idle, a tie goes to the port that was not granted
// last. Reads return one cycle after acceptance on the accepting port's
// rvalid strobe.
//
// Ports
//   CLK                  rising-edge clock shared with the SRAM wrapper
//   reset                asynchronous, active-high reset
//   rX_req               port X request (held with its command until granted)
//   rX_we[3:0]           port X byte write enables, 0000 = read
//   rX_adr[12:0]         port X word address
//   rX_wdata[31:0]       port X write data
//   rX_gnt               port X grant (command accepted when req & gnt)
//   rX_rdata[31:0]       port X read data, valid while rX_rvalid is high
//   rX_rvalid            port X read-data strobe
//   mem_ME               SRAM memory enable
//   mem_WE[3:0]          SRAM byte write enables
//   mem_ADR[12:0]        SRAM word address
//   mem_D[31:0]          SRAM write data
//   mem_Q[31:0]          SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module sram_8kx32_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic        CLK,
    input  logic        reset,

    input  logic        r0_req,
    input  logic [3:0]  r0_we,
    input  logic [12:0] r0_adr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic [31:0] r0_rdata,
    output logic        r0_rvalid,

    input  logic        r1_req,
    input  logic [3:0]  r1_we,
    input  logic [12:0] r1_adr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic [31:0] r1_rdata,
    output logic        r1_rvalid,

    output logic        mem_ME,
    output logic [3:0]  mem_WE,
    output logic [12:0] mem_ADR,
    output logic [31:0] mem_D,
    input  logic [31:0] mem_Q
);

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_t;

    own_t       own_q, own_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lp_q,  lp_d;
    logic       gnt0,  gnt1;

    // Read-return strobes, one per port, one cycle behind acceptance.
    logic [1:0] rd_vld_p1;

    // Burst counter saturates at the limit so a sole requester never wraps.
    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= BMAX) ? BMAX : c + 4'd1;
    endfunction

    // ---- stage 0: combinational arbitration and SRAM drive ----
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (own_q)
                OWN0: begin
                    if (r0_req && ((cnt_q < BMAX) || !r1_req))
                        gnt0 = 1'b1;
                    else if (r1_req)
                        gnt1 = 1'b1;
                end
                OWN1: begin
                    if (r1_req && ((cnt_q < BMAX) || !r0_req))
                        gnt1 = 1'b1;
                    else if (r0_req)
                        gnt0 = 1'b1;
                end
                default: begin
                    // Tie from idle goes to the port not granted last.
                    if (r0_req && r1_req) begin
                        gnt0 = lp_q;
                        gnt1 = ~lp_q;
                    end else begin
                        gnt0 = r0_req;
                        gnt1 = r1_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        own_d = own_q;
        cnt_d = cnt_q;
        lp_d  = lp_q;
        if (gnt0) begin
            if (own_q == OWN0) begin
                cnt_d = sat_inc(cnt_q);
            end else begin
                own_d = OWN0;
                cnt_d = 4'd1;
                lp_d  = 1'b0;
            end
        end else if (gnt1) begin
            if (own_q == OWN1) begin
                cnt_d = sat_inc(cnt_q);
            end else begin
                own_d = OWN1;
                cnt_d = 4'd1;
                lp_d  = 1'b1;
            end
        end else begin
            own_d = IDLE;
            cnt_d = 4'd0;
        end
    end

    always_comb begin
        mem_WE  = 4'd0;
        mem_ADR = 13'd0;
        mem_D   = 32'd0;
        if (gnt0) begin
            mem_WE  = r0_we;
            mem_ADR = r0_adr;
            mem_D   = r0_wdata;
        end else if (gnt1) begin
            mem_WE  = r1_we;
            mem_ADR = r1_adr;
            mem_D   = r1_wdata;
        end
    end

    assign mem_ME = gnt0 | gnt1;
    assign r0_gnt = gnt0;
    assign r1_gnt = gnt1;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            own_q <= IDLE;
            cnt_q <= 4'd0;
            lp_q  <= 1'b1;
        end else begin
            own_q <= own_d;
            cnt_q <= cnt_d;
            lp_q  <= lp_d;
        end
    end

    // ---- stage 1: read return, SRAM output arrives one cycle after accept ----
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rd_vld_p1 <= 2'b00;
        end else begin
            rd_vld_p1[0] <= gnt0 && (r0_we == 4'd0);
            rd_vld_p1[1] <= gnt1 && (r1_we == 4'd0);
        end
    end

    assign r0_rvalid = rd_vld_p1[0];
    assign r1_rvalid = rd_vld_p1[1];
    assign r0_rdata  = mem_Q;
    assign r1_rdata  = mem_Q;

endmodule

// File: tb/tb_sram_8kx32_arbiter.sv
module tb_sram_8kx32_arbiter;

    localparam int BM = 4;

    logic        CLK;
    logic        reset;
    logic        r0_req, r1_req;
    logic [3:0]  r0_we, r1_we;
    logic [12:0] r0_adr, r1_adr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_ME;
    logic [3:0]  mem_WE;
    logic [12:0] mem_ADR;
    logic [31:0] mem_D;
    logic [31:0] mem_Q = 32'd0;

    sram_8kx32_arbiter #(.BURST_MAX(BM)) dut (
        .CLK(CLK), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .mem_ME(mem_ME), .mem_WE(mem_WE), .mem_ADR(mem_ADR), .mem_D(mem_D),
        .mem_Q(mem_Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 5)            return 32'hCAFEF00D;
        if (i == 32'h1ABC)     return 32'hFFFFFFFF;
        return 32'(i) * 32'h9E3779B9;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // SRAM behaviour around the DUT
    logic        do_init;
    logic [31:0] sram [0:8191];
    always @(posedge CLK) begin
        if (do_init) begin
            for (int i = 0; i < 8192; i++) sram[i] <= init_word(i);
        end else if (mem_ME) begin
            if (mem_WE == 4'd0) mem_Q <= sram[mem_ADR];
            else                sram[mem_ADR] <= merge(sram[mem_ADR], mem_D, mem_WE);
        end
    end

    // Reference model: owner (-1 none), run length, last granted port,
    // shadow memory and expected read returns.
    int          m_own, m_run, m_last, last_g;
    logic [31:0] shadow [0:8191];
    logic        exp_rv0, exp_rv1;
    logic [31:0] exp_rd0, exp_rd1;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_pick(input logic q0, input logic q1);
        logic qx, qy;
        if (m_own < 0) begin
            if (q0 && q1) return 1 - m_last;
            if (q0) return 0;
            if (q1) return 1;
            return -1;
        end
        qx = (m_own == 1) ? q1 : q0;
        qy = (m_own == 1) ? q0 : q1;
        if (qx && (m_run < BM || !qy)) return m_own;
        if (qy) return 1 - m_own;
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_run = 0; m_last = 1;
        exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    endtask

    task automatic cycle(input logic q0, input logic [3:0] w0, input logic [12:0] a0,
                         input logic [31:0] d0, input logic q1, input logic [3:0] w1,
                         input logic [12:0] a1, input logic [31:0] d1);
        int g;
        logic [3:0]  ewe;
        logic [12:0] ea;
        logic [31:0] ed;
        @(negedge CLK);
        chk("r0_rvalid", 32'(r0_rvalid), 32'(exp_rv0));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(exp_rv1));
        if (exp_rv0) chk("r0_rdata", r0_rdata, exp_rd0);
        if (exp_rv1) chk("r1_rdata", r1_rdata, exp_rd1);
        r0_req = q0; r0_we = w0; r0_adr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_adr = a1; r1_wdata = d1;
        #1;
        g = m_pick(q0, q1);
        ewe = (g == 0) ? w0 : (g == 1) ? w1 : 4'd0;
        ea  = (g == 0) ? a0 : (g == 1) ? a1 : 13'd0;
        ed  = (g == 0) ? d0 : (g == 1) ? d1 : 32'd0;
        chk("r0_gnt", 32'(r0_gnt), 32'(g == 0));
        chk("r1_gnt", 32'(r1_gnt), 32'(g == 1));
        chk("mem_ME", 32'(mem_ME), 32'(g >= 0));
        chk("mem_WE", 32'(mem_WE), 32'(ewe));
        chk("mem_ADR", 32'(mem_ADR), 32'(ea));
        chk("mem_D", mem_D, ed);
        exp_rv0 = (g == 0) && (w0 == 4'd0);
        exp_rv1 = (g == 1) && (w1 == 4'd0);
        if (g >= 0) begin
            if (ewe == 4'd0) begin
                exp_rd0 = shadow[ea];
                exp_rd1 = shadow[ea];
            end else begin
                shadow[ea] = merge(shadow[ea], ed, ewe);
            end
        end
        if (g < 0) begin
            m_own = -1; m_run = 0;
        end else if (g == m_own) begin
            m_run = (m_run + 1 > BM) ? BM : m_run + 1;
        end else begin
            m_own = g; m_run = 1; m_last = g;
        end
        last_g = g;
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 13'd0, 32'd0, 1'b0, 4'd0, 13'd0, 32'd0);
    endtask

    // Asserts reset just after a falling edge, with both ports requesting,
    // and checks the forced outputs before releasing it on a falling edge.
    task automatic apply_reset(input int ncyc);
        @(negedge CLK);
        #2;
        reset = 1'b1;
        r0_req = 1'b1; r0_we = 4'd0;
        r1_req = 1'b1; r1_we = 4'hF;
        #1;
        chk("rst_r0_gnt", 32'(r0_gnt), 32'd0);
        chk("rst_r1_gnt", 32'(r1_gnt), 32'd0);
        chk("rst_mem_ME", 32'(mem_ME), 32'd0);
        chk("rst_mem_WE", 32'(mem_WE), 32'd0);
        chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
        repeat (ncyc) @(posedge CLK);
        @(negedge CLK);
        chk("rst_hold_r0_rvalid", 32'(r0_rvalid), 32'd0);
        chk("rst_hold_r1_rvalid", 32'(r1_rvalid), 32'd0);
        chk("rst_hold_mem_ME", 32'(mem_ME), 32'd0);
        reset = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        model_reset();
    endtask

    int          pat [0:11];
    logic        q0, q1;
    logic [3:0]  w0, w1;

    initial begin
        reset = 1'b1; do_init = 1'b1;
        r0_req = 1'b0; r0_we = 4'd0; r0_adr = 13'd0; r0_wdata = 32'd0;
        r1_req = 1'b0; r1_we = 4'd0; r1_adr = 13'd0; r1_wdata = 32'd0;
        for (int i = 0; i < 8192; i++) shadow[i] = init_word(i);
        model_reset();
        last_g = -1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        do_init = 1'b0;
        apply_reset(2);

        // Single read of a preloaded word
        cycle(1'b1, 4'd0, 13'h0005, 32'd0, 1'b0, 4'd0, 13'd0, 32'd0);
        chk("single_read_gnt", 32'(last_g), 32'd0);
        idle();
        chk("single_read_rvalid", 32'(r0_rvalid), 32'd1);
        chk("single_read_data", r0_rdata, 32'hCAFEF00D);
        chk("single_read_r1_rvalid", 32'(r1_rvalid), 32'd0);

        // Byte write then read-back on the next cycle
        cycle(1'b0, 4'd0, 13'd0, 32'd0, 1'b1, 4'b0101, 13'h1ABC, 32'h11223344);
        cycle(1'b0, 4'd0, 13'd0, 32'd0, 1'b1, 4'b0000, 13'h1ABC, 32'd0);
        idle();
        chk("byte_write_data", r1_rdata, 32'hFF22FF44);
        chk("byte_write_rvalid", 32'(r1_rvalid), 32'd1);

        // Tie after reset and burst limit with both requesting
        apply_reset(1);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 4'd0, 13'(i), 32'd0, 1'b1, 4'd0, 13'(100 + i), 32'd0);
            pat[i] = last_g;
        end
        chk("tie_first_grant", 32'(pat[0]), 32'd0);
        for (int i = 0; i < 12; i++)
            chk("burst_pattern", 32'(pat[i]), 32'((i / 4) % 2));

        // Sole requester keeps the grant; saturated count yields on contention
        idle();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 4'd0, 13'(200 + i), 32'd0, 1'b0, 4'd0, 13'd0, 32'd0);
            chk("sole_req_grant", 32'(last_g), 32'd0);
        end
        cycle(1'b1, 4'd0, 13'd7, 32'd0, 1'b1, 4'd0, 13'd9, 32'd0);
        chk("sole_req_saturated", 32'(last_g), 32'd1);

        // Reset one cycle after an r1 read is accepted
        cycle(1'b0, 4'd0, 13'd0, 32'd0, 1'b1, 4'd0, 13'd9, 32'd0);
        apply_reset(1);
        cycle(1'b1, 4'd0, 13'd3, 32'd0, 1'b1, 4'd0, 13'd4, 32'd0);
        chk("post_reset_tie", 32'(last_g), 32'd0);

        // Randomized traffic on a small address window
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                apply_reset(1);
            end else begin
                q0 = ($urandom_range(0, 9) < 7);
                q1 = ($urandom_range(0, 9) < 7);
                w0 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
                w1 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
                cycle(q0, w0, 13'($urandom_range(0, 15)), $urandom,
                      q1, w1, 13'($urandom_range(0, 15)), $urandom);
            end
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
